// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared types and defaults for the SPI transfer sequencer.
package spi_xfer_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_DRAIN,
        ST_HOLD
    } xfer_state_e;

    localparam int NSS_NUM_DEF   = 4;
    localparam int LEN_WIDTH_DEF = 5;
    localparam int SETUP_CYC_DEF = 2;
    localparam int HOLD_CYC_DEF  = 2;

    // Width of the shared SETUP/HOLD down-counter; it is loaded with cycles-1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: CS setup, edge counting, drain, CS hold.
module spi_xfer_ctrl
    import spi_xfer_ctrl_pkg::*;
#(
    parameter int NSS_NUM   = NSS_NUM_DEF,
    parameter int LEN_WIDTH = LEN_WIDTH_DEF,
    parameter int SETUP_CYC = SETUP_CYC_DEF,
    parameter int HOLD_CYC  = HOLD_CYC_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       cpol_i,
    input  logic                       cpha_i,
    input  logic [LEN_WIDTH-1:0]       len_i,
    input  logic [$clog2(NSS_NUM)-1:0] cs_sel_i,
    input  logic                       xfer_valid_i,
    output logic                       xfer_ready_o,
    input  logic                       abort_i,
    input  logic                       pos_edge_i,
    input  logic                       neg_edge_i,
    input  logic                       spi_clk_i,
    output logic                       en_o,
    output logic                       st_o,
    output logic                       last_o,
    output logic [NSS_NUM-1:0]         cs_n_o,
    output logic                       shift_o,
    output logic                       sample_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       aborted_o
);

    localparam int CS_W  = $clog2(NSS_NUM);
    localparam int CNT_W = cnt_width(SETUP_CYC, HOLD_CYC);
    localparam int BC_W  = LEN_WIDTH + 1;

    xfer_state_e          r_state, w_state_nxt;
    logic [LEN_WIDTH-1:0] r_len;
    logic [CS_W-1:0]      r_cs_sel;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [BC_W-1:0]      r_bit_cnt, w_bit_cnt_nxt;
    logic                 r_en, r_last, r_done, r_aborted;
    logic [NSS_NUM-1:0]   r_cs_n;

    logic [BC_W-1:0]      w_bits;
    logic [CS_W-1:0]      w_sel;
    logic                 w_accept, w_abort, w_sample_edge, w_shift_edge;
    logic                 w_sample, w_shift, w_st, w_done_nxt, w_aborted_nxt;
    logic                 w_en_nxt, w_last_nxt;
    logic [NSS_NUM-1:0]   w_cs_n_nxt;

    // Ready is held off during the done cycle so a held request waits one cycle.
    assign xfer_ready_o  = (r_state == ST_IDLE) && !r_done;
    assign w_accept      = xfer_valid_i && xfer_ready_o;
    assign w_abort       = abort_i && (r_state != ST_IDLE);
    assign w_bits        = {1'b0, r_len} + BC_W'(1);
    assign w_sel         = (r_state == ST_IDLE) ? cs_sel_i : r_cs_sel;
    assign w_sample_edge = (cpol_i ^ cpha_i) ? neg_edge_i : pos_edge_i;
    assign w_shift_edge  = (cpol_i ^ cpha_i) ? pos_edge_i : neg_edge_i;
    // Strobes only while shifting; an abort in the same cycle wins.
    assign w_sample      = (r_state == ST_XFER) && w_sample_edge && !abort_i;
    assign w_shift       = (r_state == ST_XFER) && w_shift_edge && !abort_i
                           && (r_bit_cnt != w_bits);

    assign sample_o  = w_sample;
    assign shift_o   = w_shift;
    assign st_o      = w_st;
    assign en_o      = r_en;
    assign last_o    = r_last;
    assign cs_n_o    = r_cs_n;
    assign busy_o    = (r_state != ST_IDLE);
    assign done_o    = r_done;
    assign aborted_o = r_aborted;

    // Next-state logic; the shared down-counter times both SETUP and HOLD.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_st          = 1'b0;
        w_done_nxt    = 1'b0;
        w_aborted_nxt = 1'b0;
        case (r_state)
            ST_IDLE: if (w_accept) begin
                w_state_nxt   = ST_SETUP;
                w_cnt_nxt     = CNT_W'(SETUP_CYC - 1);
                w_bit_cnt_nxt = '0;
            end
            ST_SETUP: if (r_cnt == '0) begin
                w_st        = 1'b1;
                w_state_nxt = ST_XFER;
            end else begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end
            ST_XFER: if (w_sample) begin
                w_bit_cnt_nxt = r_bit_cnt + BC_W'(1);
                if ((r_bit_cnt + BC_W'(1)) == w_bits) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (spi_clk_i == cpol_i) begin
                w_state_nxt = ST_HOLD;
                w_cnt_nxt   = CNT_W'(HOLD_CYC - 1);
            end
            ST_HOLD: if (r_cnt == '0) begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt   = ST_IDLE;
            w_st          = 1'b0;
            w_done_nxt    = 1'b1;
            w_aborted_nxt = 1'b1;
        end
    end

    // Registered outputs decoded from the next state, so they are glitch-free.
    always_comb begin
        w_en_nxt   = (w_state_nxt == ST_XFER) || (w_state_nxt == ST_DRAIN);
        w_last_nxt = (w_state_nxt == ST_DRAIN);
        w_cs_n_nxt = '1;
        if (w_state_nxt != ST_IDLE) w_cs_n_nxt[w_sel] = 1'b0;
    end

    // State, counters and latched request fields.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_len     <= '0;
            r_cs_sel  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            if (w_accept) begin
                r_len    <= len_i;
                r_cs_sel <= cs_sel_i;
            end
        end
    end

    // Output registers; reset releases CS immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_en      <= 1'b0;
            r_last    <= 1'b0;
            r_cs_n    <= '1;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_en      <= w_en_nxt;
            r_last    <= w_last_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_done    <= w_done_nxt;
            r_aborted <= w_aborted_nxt;
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl with a behavioural SCK generator.
module tb_spi_xfer_ctrl;

    localparam int SETUP_CYC = 2;

    typedef struct {
        int         samples;
        int         shifts;
        logic [3:0] cs_n;
        logic       aborted;
        logic       cpol;
        int         lasts;
    } exp_t;

    logic       clk, rst_n, cpol, cpha, xfer_valid, abort_r;
    logic [4:0] len;
    logic [1:0] cs_sel;
    logic       xfer_ready, en, st, last, shift, sample, busy, done, aborted;
    logic [3:0] cs_n;
    logic       sck, pos_e, neg_e;
    int         div, gcnt;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int   n_samp, n_shift, n_st, n_last, bad_cs, bad_ready, bad_edge;
    int   cs_cyc, setup_len, bad_idle;
    logic edge_seen, prev_last;

    spi_xfer_ctrl dut (
        .clk_i(clk), .rst_n_i(rst_n), .cpol_i(cpol), .cpha_i(cpha),
        .len_i(len), .cs_sel_i(cs_sel), .xfer_valid_i(xfer_valid),
        .xfer_ready_o(xfer_ready), .abort_i(abort_r), .pos_edge_i(pos_e),
        .neg_edge_i(neg_e), .spi_clk_i(sck), .en_o(en), .st_o(st),
        .last_o(last), .cs_n_o(cs_n), .shift_o(shift), .sample_o(sample),
        .busy_o(busy), .done_o(done), .aborted_o(aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SCK generator: toggles every div+1 cycles while enabled, parks at idle level when last.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck <= 1'b0; pos_e <= 1'b0; neg_e <= 1'b0; gcnt <= 0;
        end else begin
            pos_e <= 1'b0; neg_e <= 1'b0;
            if (!en) begin
                sck <= cpol; gcnt <= 0;
            end else if (gcnt >= div) begin
                gcnt <= 0;
                if (!(last && sck == cpol)) begin
                    sck <= ~sck;
                    if (!sck) pos_e <= 1'b1; else neg_e <= 1'b1;
                end
            end else begin
                gcnt <= gcnt + 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_acc();
        n_samp = 0; n_shift = 0; n_st = 0; n_last = 0; bad_cs = 0;
        bad_ready = 0; bad_edge = 0; cs_cyc = 0; setup_len = 0; edge_seen = 1'b0;
    endtask

    // Monitor: accumulates per-transfer activity and scores it at each done_o.
    initial begin
        exp_t e;
        clr_acc(); bad_idle = 0; prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                clr_acc(); prev_last = 1'b0;
            end else begin
                if (busy) begin
                    if (sample) begin
                        n_samp++;
                        if (sck != !(cpol ^ cpha)) bad_edge++;
                    end
                    if (shift) n_shift++;
                    if (st) n_st++;
                    if (last && !prev_last) n_last++;
                    if (xfer_ready) bad_ready++;
                    if (exp_q.size() > 0 && cs_n != exp_q[0].cs_n) bad_cs++;
                    if (!edge_seen) begin
                        if (pos_e || neg_e) begin setup_len = cs_cyc; edge_seen = 1'b1; end
                        else cs_cyc++;
                    end
                end else if (sample || shift || st) begin
                    bad_idle++;
                end
                prev_last = last;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("samples", n_samp, e.samples);
                        check("shifts", n_shift, e.shifts);
                        check("aborted", int'(aborted), int'(e.aborted));
                        check("st_pulses", n_st, 1);
                        check("last_sets", n_last, e.lasts);
                        check("cs_at_done", int'(cs_n), 15);
                        check("en_at_done", int'(en), 0);
                        check("last_at_done", int'(last), 0);
                        check("cs_during_xfer", bad_cs, 0);
                        check("ready_while_busy", bad_ready, 0);
                        check("sample_sck_level", bad_edge, 0);
                        checks++;
                        if (setup_len < SETUP_CYC) begin
                            errors++;
                            $display("FAIL setup_time: got %0d expected >= %0d", setup_len, SETUP_CYC);
                        end
                        if (!e.aborted) check("sck_idle_at_done", int'(sck), int'(e.cpol));
                    end
                    clr_acc();
                end
            end
        end
    end

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done) break;
        end
        if (k == 3000) check({name, "_done_timeout"}, 0, 1);
    endtask

    task automatic run_xfer(input logic pl, input logic ph, input int dv, input int ln,
                            input int sel, input int abort_after);
        exp_t e;
        int k, seen;
        @(posedge clk); #1;
        cpol = pl; cpha = ph; div = dv; len = 5'(ln); cs_sel = 2'(sel);
        e.samples = (abort_after != 0) ? abort_after : ln + 1;
        e.shifts  = ph ? e.samples : e.samples - 1;
        e.cs_n    = ~(4'b0001 << sel);
        e.aborted = (abort_after != 0);
        e.cpol    = pl;
        e.lasts   = (abort_after != 0) ? 0 : 1;
        exp_q.push_back(e);
        xfer_valid = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (xfer_ready) break;
        end
        if (k == 20) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        xfer_valid = 1'b0;
        if (abort_after != 0) begin
            seen = 0;
            for (k = 0; k < 2000 && seen < abort_after; k++) begin
                @(negedge clk);
                if (sample) seen++;
            end
            if (seen < abort_after) check("abort_wait_timeout", seen, abort_after);
            @(posedge clk); #1 abort_r = 1'b1;
            @(posedge clk); #1 abort_r = 1'b0;
        end
        wait_done("xfer");
        @(posedge clk); #1;
    endtask

    initial begin
        int k, seen, ln;
        rst_n = 1'b1; cpol = 1'b0; cpha = 1'b0; xfer_valid = 1'b0; abort_r = 1'b0;
        len = '0; cs_sel = '0; div = 0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_cs_n", int'(cs_n), 15);
        check("rst_en", int'(en), 0);
        check("rst_st", int'(st), 0);
        check("rst_last", int'(last), 0);
        check("rst_ready", int'(xfer_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_aborted", int'(aborted), 0);
        check("rst_sample_shift", int'({sample, shift}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_xfer(1'b0, 1'b0, 0, 7, 2, 0);     // mode0, 8 bits on CS2
        run_xfer(1'b1, 1'b1, 3, 31, 0, 0);    // mode3, 32 bits, slow SCK
        run_xfer(1'b0, 1'b1, 1, 0, 1, 0);     // mode1, single bit
        run_xfer(1'b1, 1'b0, 2, 0, 3, 0);     // mode2, single bit
        run_xfer(1'b0, 1'b0, 1, 15, 0, 3);    // abort after 3 samples

        // Back-to-back with request held high across done.
        @(posedge clk); #1;
        cpol = 1'b0; cpha = 1'b0; div = 0; len = 5'd3; cs_sel = 2'd1;
        for (k = 0; k < 2; k++)
            exp_q.push_back('{samples: 4, shifts: 3, cs_n: 4'b1101, aborted: 1'b0, cpol: 1'b0, lasts: 1});
        xfer_valid = 1'b1;
        wait_done("b2b_first");
        check("b2b_ready_at_done", int'(xfer_ready), 0);
        @(negedge clk);
        check("b2b_ready_after_done", int'(xfer_ready), 1);
        check("b2b_cs_gap", int'(cs_n), 15);
        @(posedge clk); #1 xfer_valid = 1'b0;
        @(negedge clk);
        check("b2b_second_accepted", int'(busy), 1);
        wait_done("b2b_second");
        @(posedge clk); #1;

        // Reset in the middle of XFER.
        cpol = 1'b0; cpha = 1'b0; div = 1; len = 5'd15; cs_sel = 2'd3;
        xfer_valid = 1'b1;
        @(posedge clk); #1 xfer_valid = 1'b0;
        seen = 0;
        for (k = 0; k < 500 && seen < 2; k++) begin
            @(negedge clk);
            if (sample) seen++;
        end
        check("rst_mid_reached_xfer", seen, 2);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("rst_mid_cs_n", int'(cs_n), 15);
        check("rst_mid_en", int'(en), 0);
        check("rst_mid_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_xfer(1'b0, 1'b0, 0, 5, 2, 0);

        // Randomized transfers, some aborted part way.
        for (int i = 0; i < 16; i++) begin
            ln = int'($urandom_range(0, 31));
            run_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), ln, int'($urandom_range(0, 3)),
                     (ln > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, ln)) : 0);
        end

        repeat (5) @(posedge clk);
        #1;
        check("strobes_while_idle", bad_idle, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
